// File: rtl/stereo_pkg.sv
// Shared definitions for the stereo capture controller.
// Contents: FSM state encodings, eye select constants, frame size and counter-width helpers.
package stereo_pkg;

  // Capture sequencer states.
  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StEnL    = 3'd1;
  localparam logic [2:0] StDrainL = 3'd2;
  localparam logic [2:0] StGap    = 3'd3;
  localparam logic [2:0] StEnR    = 3'd4;
  localparam logic [2:0] StDrainR = 3'd5;
  localparam logic [2:0] StFin    = 3'd6;

  // Value carried on out_eye.
  localparam logic EyeL = 1'b0;
  localparam logic EyeR = 1'b1;

  // Number of bytes in one eye frame.
  function automatic int unsigned frame_bytes(int unsigned n, int unsigned m, int unsigned bpp);
    return n * m * bpp;
  endfunction

  // Width of a counter that holds 0..n-1 (at least one bit).
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_pos_counter.sv
// Tracks the position of the current byte inside an eye frame.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   inc               advance by one accepted byte
//   clr               return to byte 0 of pixel 0 of row 0 (wins over inc)
//   byte_idx/col/row  position of the next byte to be accepted
//   eol               next byte is the last of its row
//   eof               next byte is the last of the frame
module pixel_pos_counter
  import stereo_pkg::*;
#(
  parameter int unsigned N   = 450,
  parameter int unsigned M   = 450,
  parameter int unsigned BPP = 3,
  localparam int unsigned BW = idx_w(BPP),
  localparam int unsigned CW = idx_w(N),
  localparam int unsigned RW = idx_w(M)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [BW-1:0] byte_idx,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          eol,
  output logic          eof
);

  localparam logic [BW-1:0] ByteLast = BW'(BPP - 1);
  localparam logic [CW-1:0] ColLast  = CW'(N - 1);
  localparam logic [RW-1:0] RowLast  = RW'(M - 1);

  logic [BW-1:0] byte_q, byte_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          last_byte, last_col, last_row;

  always_comb begin
    last_byte = (byte_q == ByteLast);
    last_col  = (col_q == ColLast);
    last_row  = (row_q == RowLast);
    byte_d    = byte_q;
    col_d     = col_q;
    row_d     = row_q;
    if (clr) begin
      byte_d = '0;
      col_d  = '0;
      row_d  = '0;
    end else if (inc) begin
      if (!last_byte) begin
        byte_d = byte_q + 1'b1;
      end else begin
        byte_d = '0;
        if (!last_col) begin
          col_d = col_q + 1'b1;
        end else begin
          col_d = '0;
          row_d = last_row ? '0 : row_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
    end else begin
      byte_q <= byte_d;
      col_q  <= col_d;
      row_q  <= row_d;
    end
  end

  assign byte_idx = byte_q;
  assign col      = col_q;
  assign row      = row_q;
  assign eol      = last_byte && last_col;
  assign eof      = last_byte && last_col && last_row;

endmodule

// File: rtl/stereo_capture_ctrl.sv
// Stereo capture sequencer: enables the left source for one frame, waits for its bytes, idles
// GAP_CYC cycles, then repeats for the right source. Both byte streams are muxed onto one
// registered, eye-tagged output with start-of-frame, end-of-line and end-of-frame markers.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start, abort          capture start pulse (idle only), capture abort level
//   cam_en_l/r            source enables (never both high)
//   valid_l/r, data_l/r   source byte streams
//   out_valid/data/eye    tagged output byte, one cycle after the source byte
//   out_sof/eol/eof       frame/row markers qualified by out_valid
//   busy, done, err       not idle, end-of-capture pulse, sticky protocol error
module stereo_capture_ctrl
  import stereo_pkg::*;
#(
  parameter int unsigned N       = 450,
  parameter int unsigned M       = 450,
  parameter int unsigned BPP     = 3,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       cam_en_l,
  output logic       cam_en_r,
  input  logic       valid_l,
  input  logic [7:0] data_l,
  input  logic       valid_r,
  input  logic [7:0] data_r,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_eye,
  output logic       out_sof,
  output logic       out_eol,
  output logic       out_eof,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned FrameBytes = frame_bytes(N, M, BPP);
  localparam int unsigned CntW       = $clog2(FrameBytes + 1);
  localparam int unsigned GapW       = idx_w(GAP_CYC);

  localparam logic [CntW-1:0] ReqLast = CntW'(FrameBytes - 1);
  localparam logic [CntW-1:0] RxFull  = CntW'(FrameBytes);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYC - 1);

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] req_cnt_q, req_cnt_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            err_q, err_d;

  logic       out_valid_q, out_eye_q, out_sof_q, out_eol_q, out_eof_q;
  logic [7:0] out_data_q;

  logic eye_sel, eye_active, sel_valid, other_valid;
  logic start_acc, eye_done, accept, err_set, pos_clr;
  logic pos_eol, pos_eof;

  logic [idx_w(BPP)-1:0] pos_byte;
  logic [idx_w(N)-1:0]   pos_col;
  logic [idx_w(M)-1:0]   pos_row;
  logic                  unused_pos;

  // Receive-side decode.
  always_comb begin
    eye_sel     = (state_q == StEnR) || (state_q == StDrainR);
    eye_active  = eye_sel || (state_q == StEnL) || (state_q == StDrainL);
    // Outside an eye window (GAP/FIN) both inputs count as unselected: sel_valid is then
    // valid_l and is flagged through the !eye_active term below.
    sel_valid   = eye_sel ? valid_r : valid_l;
    other_valid = eye_sel ? valid_l : valid_r;
    start_acc   = (state_q == StIdle) && start && !abort;
    eye_done    = ((state_q == StDrainL) || (state_q == StDrainR)) && (rx_cnt_q == RxFull);
    accept      = !abort && eye_active && sel_valid && (rx_cnt_q != RxFull);
    // Idle traffic (e.g. the byte still in flight after abort or reset) is not an error.
    err_set     = !abort && (state_q != StIdle) &&
                  (other_valid || (sel_valid && (!eye_active || (rx_cnt_q == RxFull))));
    pos_clr     = start_acc || eye_done || abort;
  end

  // Sequencer.
  always_comb begin
    state_d   = state_q;
    req_cnt_d = '0;
    gap_d     = '0;
    if (abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) state_d = StEnL;
        end
        StEnL, StEnR: begin
          if (req_cnt_q == ReqLast) begin
            state_d = (state_q == StEnL) ? StDrainL : StDrainR;
          end else begin
            req_cnt_d = req_cnt_q + 1'b1;
          end
        end
        StDrainL: begin
          if (eye_done) state_d = StGap;
        end
        StGap: begin
          if (gap_q == GapLast) state_d = StEnR;
          else gap_d = gap_q + 1'b1;
        end
        StDrainR: begin
          if (eye_done) state_d = StFin;
        end
        StFin: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_comb begin
    if (pos_clr) rx_cnt_d = '0;
    else if (accept) rx_cnt_d = rx_cnt_q + 1'b1;
    else rx_cnt_d = rx_cnt_q;

    if (start_acc) err_d = 1'b0;
    else if (err_set) err_d = 1'b1;
    else err_d = err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      req_cnt_q   <= '0;
      rx_cnt_q    <= '0;
      gap_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_eye_q   <= EyeL;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_cnt_q   <= req_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      gap_q       <= gap_d;
      err_q       <= err_d;
      out_valid_q <= accept;
      out_sof_q   <= accept && (rx_cnt_q == '0);
      out_eol_q   <= accept && pos_eol;
      out_eof_q   <= accept && pos_eof;
      if (accept) begin
        out_data_q <= eye_sel ? data_r : data_l;
        out_eye_q  <= eye_sel ? EyeR : EyeL;
      end
    end
  end

  pixel_pos_counter #(
    .N  (N),
    .M  (M),
    .BPP(BPP)
  ) u_pos (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (accept),
    .clr     (pos_clr),
    .byte_idx(pos_byte),
    .col     (pos_col),
    .row     (pos_row),
    .eol     (pos_eol),
    .eof     (pos_eof)
  );

  // Raw position is only needed through eol/eof here.
  assign unused_pos = ^{pos_byte, pos_col, pos_row};

  assign cam_en_l  = (state_q == StEnL);
  assign cam_en_r  = (state_q == StEnR);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFin);
  assign err       = err_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_eye   = out_eye_q;
  assign out_sof   = out_sof_q;
  assign out_eol   = out_eol_q;
  assign out_eof   = out_eof_q;

endmodule
